addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Sequencing arbiter that shares one 16-bit add/subtract datapath (AddSub16b, 4-bit ripple-chained, carry-in = i_fSub) between two requesters. It accepts one operation at a time through a request/acknowledge handshake, latches operands, drives the shared adder, registers the result, and returns it on a valid/ready response channel to the granting requester. Round-robin arbitration by default; fixed priority optional. Sits between the two client blocks and the single arithmetic unit.

## Interface
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins ties
- i_Clk  in  1  clock, all state updates on rising edge
- i_Rst  in  1  synchronous reset, active-high
- i_Req0 / i_Req1  in  1  request from requester 0 / 1, level, held until ack
- i_A0, i_B0 / i_A1, i_B1  in  16 each  operands, stable while request is high
- i_fSub0 / i_fSub1  in  1  0 = A+B, 1 = A-B
- o_Ack0 / o_Ack1  out  1  one-cycle pulse: request accepted, operands latched
- o_Vld0 / o_Vld1  out  1  result valid for requester 0 / 1
- i_Rdy0 / i_Rdy1  in  1  requester consumes result when Vld && Rdy
- o_S  out  16  shared registered result bus
- o_C  out  1  registered carry out; for subtract, 1 = no borrow (A >= B unsigned)
- o_Busy  out  1  high whenever state != IDLE

## Operation
- One clock, synchronous active-high reset. Reset values: state IDLE, priority pointer 0, o_Ack0/1 = 0, o_Vld0/1 = 0, o_S = 0x0000, o_C = 0, o_Busy = 0, latched operands 0.
- Internal regs: r_A, r_B (16), r_fSub, r_Gnt (1, owner), r_Pri (1, next preferred requester).
- One AddSub16b instance fed by r_A, r_B, r_fSub. Its outputs are registered into o_S/o_C; no combinational path from any input to o_S/o_C.
- States: IDLE, CALC, RESP.
- IDLE: no request -> stay. Single request -> grant it. Both -> RR_EN=1: grant r_Pri; RR_EN=0: grant 0. On grant: latch operands and fSub of the winner, r_Gnt <= winner, r_Pri <= ~winner (RR_EN=1 only), next CALC.
- CALC: o_AckN = 1 for owner only; o_S/o_C <= adder result at end of cycle; next RESP. Requests ignored.
- RESP: o_VldN = 1 for owner only, o_S/o_C held stable. i_RdyN (owner's) high -> next IDLE, Vld drops. Rdy low -> stay, hold everything. The non-owner's Rdy is ignored.
- Arithmetic: modulo 2^16, unsigned carry; no overflow flag. Subtract is A + ~B + 1.
- Requester must deassert Req on the edge after seeing Ack; a Req still high in IDLE is a new request.
- Reset mid-operation (CALC or RESP): pending result dropped, no Vld issued, all outputs to reset values on the next edge.

## Timing
- Request sampled at edge T (state IDLE) -> Ack high in cycle T+1 (CALC) -> Vld high from cycle T+2 (RESP).
- Zero-stall throughput: one operation per 3 cycles; next grant evaluated in the cycle after the Vld&&Rdy edge.
- Ack and Vld are never high for both requesters in the same cycle; Ack and Vld never high together.
- o_S/o_C change only on the CALC->RESP edge or reset.
- Simultaneous request and reset: reset wins, no grant.
- Waiting requester's Req may stay high indefinitely; with RR_EN=1 it is granted at the next IDLE (no starvation, max wait one operation).

## Test plan
- Reset then single add: Req0, A0=0x1234, B0=0x0FFF, fSub0=0, Rdy0=1 -> Ack0 at T+1, Vld0 at T+2, o_S=0x2233, o_C=0; Vld1/Ack1 stay 0.
- Subtract with/without borrow via requester 1: 0x0005-0x0007 -> o_S=0xFFFE, o_C=0; 0x0007-0x0005 -> o_S=0x0002, o_C=1; wrap 0xFFFF+0x0001 -> o_S=0x0000, o_C=1.
- Contention, RR_EN=1: Req0 and Req1 held high continuously, Rdy both 1 -> grants alternate 0,1,0,1 starting with 0 after reset, each Vld spaced 3 cycles; with RR_EN=0 requester 0 wins every tie.
- Backpressure: Rdy0=0 for 5 cycles in RESP -> Vld0, o_S, o_C, o_Busy held stable all 5 cycles; pending Req1 not granted until cycle after Rdy0=1.
- Reset mid-operation: assert i_Rst in CALC and separately in RESP -> next edge all outputs 0, state IDLE, no Vld for dropped op, priority pointer back to 0.
- Back-to-back same requester: Req0 reasserted in IDLE right after Vld0&&Rdy0 -> new Ack0 exactly 1 cycle after the IDLE sample, new operands used, old o_S held until the new CALC->RESP edge.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter that shares one 16-bit add/subtract datapath.
// Each operation walks IDLE (grant) -> CALC (ack, compute) -> RESP (valid until owner ready).
module addsub_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Req0,
  input  logic        i_Req1,
  input  logic [15:0] i_A0,
  input  logic [15:0] i_B0,
  input  logic [15:0] i_A1,
  input  logic [15:0] i_B1,
  input  logic        i_fSub0,
  input  logic        i_fSub1,
  output logic        o_Ack0,
  output logic        o_Ack1,
  output logic        o_Vld0,
  output logic        o_Vld1,
  input  logic        i_Rdy0,
  input  logic        i_Rdy1,
  output logic [15:0] o_S,
  output logic        o_C,
  output logic        o_Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        fsub_q, fsub_d;
  logic        gnt_q, gnt_d;
  logic        pri_q, pri_d;
  logic [15:0] s_q, s_d;
  logic        c_q, c_d;

  logic [15:0] sum;
  logic [15:0] b_eff;
  logic [4:0]  carry;
  logic        winner;
  logic        owner_rdy;

  // Shared adder: four 4-bit slices rippling carry; subtract is A + ~B + 1.
  always_comb begin
    b_eff    = fsub_q ? ~b_q : b_q;
    sum      = '0;
    carry    = '0;
    carry[0] = fsub_q;
    for (int i = 0; i < 4; i++) begin
      {carry[i+1], sum[4*i +: 4]} = {1'b0, a_q[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]}
                                    + {4'b0000, carry[i]};
    end
  end

  always_comb begin
    if (i_Req0 && i_Req1) winner = RR_EN ? pri_q : 1'b0;
    else                  winner = i_Req1;
  end

  assign owner_rdy = gnt_q ? i_Rdy1 : i_Rdy0;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fsub_d  = fsub_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (i_Req0 || i_Req1) begin
          state_d = CALC;
          gnt_d   = winner;
          a_d     = winner ? i_A1    : i_A0;
          b_d     = winner ? i_B1    : i_B0;
          fsub_d  = winner ? i_fSub1 : i_fSub0;
          if (RR_EN) pri_d = ~winner;
        end
      end
      CALC: begin
        state_d = RESP;
        s_d     = sum;
        c_d     = carry[4];
      end
      RESP: begin
        if (owner_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments; reset is synchronous and sampled on the clock edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fsub_q  <= 1'b0;
      gnt_q   <= 1'b0;
      pri_q   <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fsub_q  <= fsub_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign o_Ack0 = (state_q == CALC) && !gnt_q;
  assign o_Ack1 = (state_q == CALC) &&  gnt_q;
  assign o_Vld0 = (state_q == RESP) && !gnt_q;
  assign o_Vld1 = (state_q == RESP) &&  gnt_q;
  assign o_S    = s_q;
  assign o_C    = c_q;
  assign o_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed scenarios plus random traffic, checked against a
// transaction model with an expected-response queue and a negedge monitor.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, fsub0, fsub1, rdy0, rdy1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, vld0, vld1, c, busy;
  logic [15:0] s;
  logic        fp_ack0, fp_ack1, fp_vld0, fp_vld1, fp_c, fp_busy;
  logic [15:0] fp_s;

  addsub_arbiter #(.RR_EN(1'b1)) u_rr (
    .i_Clk(clk), .i_Rst(rst), .i_Req0(req0), .i_Req1(req1),
    .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1), .i_fSub0(fsub0), .i_fSub1(fsub1),
    .o_Ack0(ack0), .o_Ack1(ack1), .o_Vld0(vld0), .o_Vld1(vld1),
    .i_Rdy0(rdy0), .i_Rdy1(rdy1), .o_S(s), .o_C(c), .o_Busy(busy)
  );

  addsub_arbiter #(.RR_EN(1'b0)) u_fp (
    .i_Clk(clk), .i_Rst(rst), .i_Req0(req0), .i_Req1(req1),
    .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1), .i_fSub0(fsub0), .i_fSub1(fsub1),
    .o_Ack0(fp_ack0), .o_Ack1(fp_ack1), .o_Vld0(fp_vld0), .o_Vld1(fp_vld1),
    .i_Rdy0(rdy0), .i_Rdy1(rdy1), .o_S(fp_s), .o_C(fp_c), .o_Busy(fp_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (round-robin instance) ----------------
  typedef struct packed {
    logic        id;
    logic [15:0] s;
    logic        c;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       m_pending;
  int          m_phase = 0;   // cycle of the operation in flight: 0 none, 1 accepted, 2 responding
  logic        m_owner = 1'b0;
  logic        m_pri   = 1'b0;
  logic [15:0] m_s     = '0;
  logic        m_c     = 1'b0;

  function automatic resp_t ref_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub);
    resp_t       r;
    logic [16:0] wide;
    r.id = id;
    if (sub) begin
      r.s = a - b;
      r.c = (a >= b);
    end else begin
      wide = a + b;
      r.s  = wide[15:0];
      r.c  = wide[16];
    end
    return r;
  endfunction

  always @(posedge clk) begin : ref_model
    logic  w;
    resp_t r;
    if (rst) begin
      m_phase <= 0;
      m_pri   <= 1'b0;
      m_owner <= 1'b0;
      m_s     <= '0;
      m_c     <= 1'b0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (req0 || req1) begin
            w = (req0 && req1) ? m_pri : req1;
            r = w ? ref_op(1'b1, a1, b1, fsub1) : ref_op(1'b0, a0, b0, fsub0);
            m_owner   <= w;
            m_pri     <= !w;
            m_pending <= r;
            exp_q.push_back(r);
            m_phase   <= 1;
          end
        end
        1: begin
          m_s     <= m_pending.s;
          m_c     <= m_pending.c;
          m_phase <= 2;
        end
        default: begin
          if (m_owner ? rdy1 : rdy0) m_phase <= 0;
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("ctrl", {ack0, ack1, vld0, vld1, busy},
          {m_phase == 1 && !m_owner, m_phase == 1 && m_owner,
           m_phase == 2 && !m_owner, m_phase == 2 && m_owner, m_phase != 0});
    check("result_reg", {c, s}, {m_c, m_s});
    if (vld0 || vld1) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else begin
        check("sb_resp", {vld1, s, c}, {exp_q[0].id, exp_q[0].s, exp_q[0].c});
        if (vld1 ? rdy1 : rdy0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [16:0] last_exp;

  task automatic run_op(input string name, input logic id, input logic [15:0] a,
                        input logic [15:0] b, input logic sub, input logic [16:0] exp_cs);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; fsub1 = sub; rdy1 = 1'b1; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; fsub0 = sub; rdy0 = 1'b1; end
    tick();
    check({name, "_ack"}, id ? {ack1, ack0, vld0, vld1} : {ack0, ack1, vld0, vld1}, 4'b1000);
    check({name, "_hold"}, {c, s}, last_exp);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
    tick();
    check({name, "_vld"}, id ? {vld1, vld0, ack0, ack1} : {vld0, vld1, ack0, ack1}, 4'b1000);
    check({name, "_res"}, {c, s}, exp_cs);
    last_exp = exp_cs;
    tick();
    check({name, "_idle"}, {busy, vld0, vld1}, 3'b000);
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [3:0]  order_rr, order_fp;
  logic [15:0] mask_rr, mask_fp;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fsub0 = 1'b0; fsub1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    last_exp = '0;
    repeat (3) tick();
    check("reset_outputs", {ack0, ack1, vld0, vld1, busy, c, s}, 0);
    rst = 1'b0;

    // single operations, including borrow/no-borrow and wrap, then back-to-back
    run_op("add",          1'b0, 16'h1234, 16'h0FFF, 1'b0, {1'b0, 16'h2233});
    run_op("sub_borrow",   1'b1, 16'h0005, 16'h0007, 1'b1, {1'b0, 16'hFFFE});
    run_op("sub_noborrow", 1'b1, 16'h0007, 16'h0005, 1'b1, {1'b1, 16'h0002});
    run_op("wrap",         1'b1, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});
    run_op("b2b_a",        1'b0, 16'h1111, 16'h2222, 1'b0, {1'b0, 16'h3333});
    run_op("b2b_b",        1'b0, 16'hF000, 16'h2000, 1'b0, {1'b1, 16'h1000});

    // contention with both requests held: round-robin alternates, fixed priority keeps 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; a0 = 16'h0010; b0 = 16'h0001; fsub0 = 1'b0;
    a1 = 16'h0020; b1 = 16'h0001; fsub1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    order_rr = '0; order_fp = '0; mask_rr = '0; mask_fp = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (vld0 || vld1) begin order_rr = {order_rr[2:0], vld1}; mask_rr[k] = 1'b1; end
      if (fp_vld0 || fp_vld1) begin
        order_fp = {order_fp[2:0], fp_vld1};
        mask_fp[k] = 1'b1;
        check("fp_res", {fp_c, fp_s}, {1'b0, 16'h0011});
      end
      check("fp_ctrl", {fp_ack0, fp_ack1, fp_busy}, {m_phase == 1, 1'b0, m_phase != 0});
    end
    check("rr_order",   order_rr, 4'b0101);
    check("rr_spacing", mask_rr,  16'h0924);
    check("fp_order",   order_fp, 4'b0000);
    check("fp_spacing", mask_fp,  16'h0924);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // backpressure on requester 0 while requester 1 waits
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; fsub0 = 1'b0; rdy0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0003; b1 = 16'h0004; fsub1 = 1'b1; rdy1 = 1'b1;
    tick();
    check("bp_ack", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {vld0, vld1, ack1, busy, c, s}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003});
      tick();
    end
    rdy0 = 1'b1;
    tick();
    check("bp_release", {vld0, ack1, busy}, 3'b000);
    tick();
    check("bp_grant1", {ack1, ack0}, 2'b10);
    req1 = 1'b0;
    tick();
    check("bp_res1", {vld1, c, s}, {1'b1, 1'b0, 16'hFFFF});
    tick();

    // reset while in CALC drops the op and the priority pointer
    req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; fsub0 = 1'b0; rdy0 = 1'b1;
    tick();
    check("rst_calc_ack", {ack0, ack1}, 2'b10);
    rst = 1'b1; req0 = 1'b0;
    tick();
    check("rst_calc_out", {ack0, ack1, vld0, vld1, busy, c, s}, 0);
    rst = 1'b0;
    tick();
    check("rst_calc_novld", {vld0, vld1, busy}, 3'b000);
    req0 = 1'b1; req1 = 1'b1; a1 = 16'h0100; b1 = 16'h0001; fsub1 = 1'b1; rdy1 = 1'b1;
    tick();
    check("rst_calc_pri", {ack0, ack1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    // reset while in RESP
    req0 = 1'b1; a0 = 16'h0ABC; b0 = 16'h0001; fsub0 = 1'b1; rdy0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    check("rst_resp_vld", {vld0, c, s}, {1'b1, 1'b1, 16'h0ABB});
    rst = 1'b1;
    tick();
    check("rst_resp_out", {ack0, ack1, vld0, vld1, busy, c, s}, 0);
    rst = 1'b0; rdy0 = 1'b1;
    tick();
    check("rst_resp_novld", {vld0, vld1, busy}, 3'b000);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("rst_resp_pri", {ack0, ack1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    // request coincident with reset is not granted
    rst = 1'b1; req1 = 1'b1;
    tick();
    check("rst_req", {ack0, ack1, busy}, 3'b000);
    rst = 1'b0; req1 = 1'b0;
    tick();
    check("rst_req_idle", {busy, ack1}, 2'b00);

    // random traffic with occasional resets and backpressure
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; a0 = rand_operand(); b0 = rand_operand(); fsub0 = 1'($urandom_range(0, 1));
      end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; a1 = rand_operand(); b1 = rand_operand(); fsub1 = 1'($urandom_range(0, 1));
      end
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      tick();
    end

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (4) tick();
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
